// File: rtl/matmul_ctrl_pkg.sv
// Shared definitions for the matmul command sequencer: FSM state encoding,
// register address codes, status bit positions and control-word field offsets.
package matmul_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_e;

    localparam logic CTRL_ADDR = 1'b0;
    localparam logic STAT_ADDR = 1'b1;

    // Control word fixed bits
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_MODE_BIT  = 1;
    localparam int CTRL_WT_LSB    = 2;

    // Status word bit positions
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_PEND_BIT = 1;
    localparam int STAT_DONE_BIT = 2;
    localparam int STAT_OVF_BIT  = 3;
    localparam int STAT_TMO_BIT  = 4;
    localparam int STAT_CNT_LSB  = 8;

    function automatic int rt_lsb(input int tgt_w);
        return CTRL_WT_LSB + tgt_w;
    endfunction

    function automatic int n_lsb(input int tgt_w);
        return CTRL_WT_LSB + 2 * tgt_w;
    endfunction

    function automatic int k_lsb(input int tgt_w, input int dim_w);
        return n_lsb(tgt_w) + dim_w;
    endfunction

    function automatic int m_lsb(input int tgt_w, input int dim_w);
        return n_lsb(tgt_w) + 2 * dim_w;
    endfunction

    // Number of low control bits that carry start plus command fields
    function automatic int ctrl_used_bits(input int tgt_w, input int dim_w);
        return n_lsb(tgt_w) + 3 * dim_w;
    endfunction

endpackage

// File: rtl/matmul_ctrl_seq_if.sv
// Bus-side register port and engine-side command/launch signals of the
// matmul command sequencer. Signal suffixes are from the sequencer's view.
//
// Handshake: wr_en_i is a single-cycle write strobe qualified by addr_i and
// data_i; there is no back-pressure, every strobe is taken on the rising edge.
// data_o is a combinational read of the register selected by addr_i and is 0
// while wr_en_i is high. calc_start_o and done_o are single-cycle pulses;
// calc_done_i is a pulse that is only observed while the engine is running.
interface matmul_ctrl_seq_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM_WIDTH  = 2,
    parameter int TGT_WIDTH  = 2
);
    import matmul_ctrl_pkg::*;

    logic                  wr_en_i;
    logic                  addr_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  calc_done_i;
    logic                  calc_start_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  mode_bit_o;
    logic [TGT_WIDTH-1:0]  write_target_o;
    logic [TGT_WIDTH-1:0]  read_target_o;
    logic [DIM_WIDTH-1:0]  n_dim_o;
    logic [DIM_WIDTH-1:0]  k_dim_o;
    logic [DIM_WIDTH-1:0]  m_dim_o;
    seq_state_e            dbg_state;

    // Bus master / engine side
    modport master (
        output wr_en_i, addr_i, data_i, calc_done_i,
        input  data_o, calc_start_o, busy_o, done_o, mode_bit_o,
               write_target_o, read_target_o, n_dim_o, k_dim_o, m_dim_o, dbg_state
    );

    // Sequencer side
    modport slave (
        input  wr_en_i, addr_i, data_i, calc_done_i,
        output data_o, calc_start_o, busy_o, done_o, mode_bit_o,
               write_target_o, read_target_o, n_dim_o, k_dim_o, m_dim_o, dbg_state
    );

endinterface

// File: rtl/matmul_cmd_slot.sv
// One-deep command holding register with a valid flag. A load overwrites the
// slot and sets valid; a take clears valid. Load wins over a same-cycle take
// so a slot can be drained and refilled in one cycle.
module matmul_cmd_slot #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         take_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    // Slot contents and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            data_o  <= load_data_i;
        end else if (take_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/matmul_ctrl_seq.sv
// Command/control sequencer for the matmul engine. Holds a staging control
// register, a one-deep pending command slot and the active command, launches
// the engine with a start pulse, waits for its done, and keeps status and a
// completed-command count.
// Optional build macro: MATMUL_CTRL_TIMEOUT_EN adds a busy watchdog that
// forces completion after TIMEOUT_CYCLES cycles without calc_done_i.
module matmul_ctrl_seq
    import matmul_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int DIM_WIDTH      = 2,
    parameter int TGT_WIDTH      = 2,
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic              clk_i,
    input logic              rst_i,
    matmul_ctrl_seq_if.slave bus
);

    // Commands are held without the start bit: bits [CMD_W:1] of a control word
    localparam int CMD_W = ctrl_used_bits(TGT_WIDTH, DIM_WIDTH) - 1;
    localparam int C_WT  = CTRL_WT_LSB - 1;
    localparam int C_RT  = rt_lsb(TGT_WIDTH) - 1;
    localparam int C_N   = n_lsb(TGT_WIDTH) - 1;
    localparam int C_K   = k_lsb(TGT_WIDTH, DIM_WIDTH) - 1;
    localparam int C_M   = m_lsb(TGT_WIDTH, DIM_WIDTH) - 1;

    if (DATA_WIDTH < ctrl_used_bits(TGT_WIDTH, DIM_WIDTH) || CNT_WIDTH > DATA_WIDTH - 8
        || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("matmul_ctrl_seq: invalid parameter combination");
    end

    seq_state_e            state_q;
    logic                  calc_start_q, done_q, busy_q;
    logic [CMD_W-1:0]      act_q;
    logic [DATA_WIDTH-1:0] stage_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  done_stk_q, ovf_stk_q, tmo_stk;
    logic                  pend_valid;
    logic [CMD_W-1:0]      pend_cmd;
    logic [CMD_W-1:0]      wr_cmd;
    logic                  ctrl_wr, stat_wr, start_req;
    logic                  to_active, pend_take, pend_load, ovf_set;
    logic                  wd_hit, fin_evt;
    logic [DATA_WIDTH-1:0] status_w;

    assign ctrl_wr   = bus.wr_en_i && (bus.addr_i == CTRL_ADDR);
    assign stat_wr   = bus.wr_en_i && (bus.addr_i == STAT_ADDR);
    assign start_req = ctrl_wr && bus.data_i[CTRL_START_BIT];
    assign wr_cmd    = bus.data_i[CMD_W:1];

    // The pending slot drains whenever the FSM is free to launch (IDLE or DONE);
    // a start arriving in that cycle refills it instead of overflowing.
    assign pend_take = pend_valid && (state_q == ST_IDLE || state_q == ST_DONE);
    assign to_active = start_req && (state_q == ST_IDLE) && !pend_valid;
    assign pend_load = start_req && !to_active && (!pend_valid || pend_take);
    assign ovf_set   = start_req && !to_active && pend_valid && !pend_take;
    assign fin_evt   = (state_q == ST_BUSY) && (bus.calc_done_i || wd_hit);

    matmul_cmd_slot #(.W(CMD_W)) u_pend (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (pend_load),
        .load_data_i (wr_cmd),
        .take_i      (pend_take),
        .valid_o     (pend_valid),
        .data_o      (pend_cmd)
    );

    // Sequencer FSM with registered launch/done/busy pulses and active command
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            calc_start_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            act_q        <= '0;
        end else begin
            calc_start_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pend_valid) begin
                        act_q        <= pend_cmd;
                        state_q      <= ST_LAUNCH;
                        calc_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end else if (to_active) begin
                        act_q        <= wr_cmd;
                        state_q      <= ST_LAUNCH;
                        calc_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                ST_LAUNCH: state_q <= ST_BUSY;
                ST_BUSY: begin
                    if (fin_evt) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (pend_valid) begin
                        act_q        <= pend_cmd;
                        state_q      <= ST_LAUNCH;
                        calc_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Staging register: stores writes with the start bit cleared
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else if (ctrl_wr) begin
            stage_q <= {bus.data_i[DATA_WIDTH-1:1], 1'b0};
        end
    end

    // Done/overflow stickies (set beats W1C) and completed-command counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_stk_q <= 1'b0;
            ovf_stk_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (stat_wr && bus.data_i[STAT_DONE_BIT]) done_stk_q <= 1'b0;
            if (stat_wr && bus.data_i[STAT_OVF_BIT])  ovf_stk_q  <= 1'b0;
            if (fin_evt) done_stk_q <= 1'b1;
            if (ovf_set) ovf_stk_q  <= 1'b1;
            if ((state_q == ST_BUSY) && bus.calc_done_i) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

`ifdef MATMUL_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    logic            tmo_stk_q;

    assign wd_hit  = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign tmo_stk = tmo_stk_q;

    // Watchdog: counts BUSY cycles, cleared whenever the FSM is elsewhere
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_q <= '0;
        end else if (state_q != ST_BUSY) begin
            wd_q <= '0;
        end else if (!wd_hit) begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    // Timeout sticky: set when the watchdog forces completion
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_stk_q <= 1'b0;
        end else begin
            if (stat_wr && bus.data_i[STAT_TMO_BIT]) tmo_stk_q <= 1'b0;
            if ((state_q == ST_BUSY) && !bus.calc_done_i && wd_hit) tmo_stk_q <= 1'b1;
        end
    end
`else
    assign wd_hit  = 1'b0;
    assign tmo_stk = 1'b0;
`endif

    // Status word assembly and read mux (reads return 0 during a write)
    always_comb begin
        status_w                                = '0;
        status_w[STAT_BUSY_BIT]                 = busy_q;
        status_w[STAT_PEND_BIT]                 = pend_valid;
        status_w[STAT_DONE_BIT]                 = done_stk_q;
        status_w[STAT_OVF_BIT]                  = ovf_stk_q;
        status_w[STAT_TMO_BIT]                  = tmo_stk;
        status_w[STAT_CNT_LSB +: CNT_WIDTH]     = cnt_q;
        if (bus.wr_en_i)                       bus.data_o = '0;
        else if (bus.addr_i == CTRL_ADDR)      bus.data_o = stage_q;
        else                                   bus.data_o = status_w;
    end

    assign bus.calc_start_o   = calc_start_q;
    assign bus.done_o         = done_q;
    assign bus.busy_o         = busy_q;
    assign bus.mode_bit_o     = act_q[0];
    assign bus.write_target_o = act_q[C_WT +: TGT_WIDTH];
    assign bus.read_target_o  = act_q[C_RT +: TGT_WIDTH];
    assign bus.n_dim_o        = act_q[C_N +: DIM_WIDTH];
    assign bus.k_dim_o        = act_q[C_K +: DIM_WIDTH];
    assign bus.m_dim_o        = act_q[C_M +: DIM_WIDTH];
    assign bus.dbg_state      = state_q;

endmodule
